// File: rtl/mpu9250_poll_sequencer.sv
// Autonomous MPU9250 sequencer: writes the sensor configuration once, then polls a
// 14-byte accel/temp/gyro burst on a timer and commits whole bursts into a word bank.
module mpu9250_poll_sequencer #(
  parameter logic [6:0]  DEV_ADDR = 7'h68,
  parameter int unsigned POLL_DIV = 100000
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic        clk_en,
  input  logic        enable,
  output logic        xfer_valid,
  input  logic        xfer_ready,
  output logic        xfer_rnw,
  output logic [6:0]  xfer_dev,
  output logic [7:0]  xfer_reg,
  output logic [7:0]  xfer_wdata,
  output logic [3:0]  xfer_len,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  input  logic        xfer_done,
  input  logic        xfer_nack,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_word,
  output logic        sample_valid,
  output logic [15:0] sample_count,
  output logic [7:0]  err_count,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, INIT_REQ, INIT_WAIT, WAIT_TICK, READ_REQ, READ_WAIT, COMMIT, BACKOFF
  } state_e;

  localparam logic [31:0] TIMER_MAX = 32'(POLL_DIV - 1);

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [1:0]  step_q, step_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  shadow_q [14];
  logic [7:0]  shadow_d [14];
  logic [15:0] bank_q [7];
  logic [15:0] bank_d [7];
  logic [15:0] rd_word_q, rd_word_d;
  logic [15:0] sample_count_q, sample_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        overrun_q, overrun_d;
  logic        xfer_valid_q, xfer_valid_d;
  logic        xfer_rnw_q, xfer_rnw_d;
  logic [7:0]  xfer_reg_q, xfer_reg_d;
  logic [7:0]  xfer_wdata_q, xfer_wdata_d;
  logic [3:0]  xfer_len_q, xfer_len_d;

  logic        tick;
  logic        load_init;
  logic        load_read;
  logic [1:0]  load_step;
  logic [3:0]  cnt_next;
  logic [7:0]  err_inc;

  function automatic logic [15:0] init_entry(input logic [1:0] idx);
    case (idx)
      2'd0:    return 16'h6B01;
      2'd1:    return 16'h1A03;
      2'd2:    return 16'h1B00;
      default: return 16'h1C00;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    step_d         = step_q;
    byte_cnt_d     = byte_cnt_q;
    rd_word_d      = rd_word_q;
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    overrun_d      = overrun_q;
    xfer_valid_d   = xfer_valid_q;
    xfer_rnw_d     = xfer_rnw_q;
    xfer_reg_d     = xfer_reg_q;
    xfer_wdata_d   = xfer_wdata_q;
    xfer_len_d     = xfer_len_q;
    for (int unsigned i = 0; i < 14; i++) shadow_d[i] = shadow_q[i];
    for (int unsigned i = 0; i < 7; i++) bank_d[i] = bank_q[i];
    tick      = 1'b0;
    load_init = 1'b0;
    load_read = 1'b0;
    load_step = step_q;
    cnt_next  = byte_cnt_q;
    err_inc   = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    if (clk_en) begin
      tick    = (state_q != IDLE) && (timer_q == TIMER_MAX);
      timer_d = (state_q == IDLE || tick) ? '0 : timer_q + 32'd1;
      if (tick && state_q != WAIT_TICK && state_q != BACKOFF) overrun_d = 1'b1;

      case (state_q)
        IDLE: begin
          if (enable) begin
            step_d    = '0;
            load_step = '0;
            load_init = 1'b1;
            state_d   = INIT_REQ;
          end
        end
        INIT_REQ: begin
          if (xfer_ready) begin
            xfer_valid_d = 1'b0;
            state_d      = INIT_WAIT;
          end
        end
        INIT_WAIT: begin
          if (xfer_done) begin
            if (xfer_nack) begin
              err_count_d = err_inc;
              state_d     = enable ? BACKOFF : IDLE;
            end else if (step_q == 2'd3) begin
              state_d = enable ? WAIT_TICK : IDLE;
            end else begin
              step_d = step_q + 2'd1;
              if (enable) begin
                load_step = step_q + 2'd1;
                load_init = 1'b1;
                state_d   = INIT_REQ;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        WAIT_TICK: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (tick) begin
            load_read = 1'b1;
            state_d   = READ_REQ;
          end
        end
        READ_REQ: begin
          if (xfer_ready) begin
            xfer_valid_d = 1'b0;
            byte_cnt_d   = '0;
            state_d      = READ_WAIT;
          end
        end
        READ_WAIT: begin
          // A byte arriving with xfer_done is stored and counted before the length test.
          if (rd_valid && byte_cnt_q < 4'd14) begin
            shadow_d[byte_cnt_q] = rd_data;
            cnt_next             = byte_cnt_q + 4'd1;
          end
          byte_cnt_d = cnt_next;
          if (xfer_done) begin
            if (!xfer_nack && cnt_next == 4'd14) begin
              state_d = COMMIT;
            end else begin
              err_count_d = err_inc;
              state_d     = enable ? WAIT_TICK : IDLE;
            end
          end
        end
        COMMIT: begin
          for (int unsigned i = 0; i < 7; i++) bank_d[i] = {shadow_q[2*i], shadow_q[2*i+1]};
          sample_count_d = sample_count_q + 16'd1;
          state_d        = enable ? WAIT_TICK : IDLE;
        end
        BACKOFF: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (tick) begin
            load_init = 1'b1;
            state_d   = INIT_REQ;
          end
        end
        default: state_d = IDLE;
      endcase

      if (load_init) begin
        xfer_valid_d             = 1'b1;
        xfer_rnw_d               = 1'b0;
        {xfer_reg_d, xfer_wdata_d} = init_entry(load_step);
        xfer_len_d               = 4'd0;
      end
      if (load_read) begin
        xfer_valid_d = 1'b1;
        xfer_rnw_d   = 1'b1;
        xfer_reg_d   = 8'h3B;
        xfer_wdata_d = 8'h00;
        xfer_len_d   = 4'd14;
      end

      // Read from next-state bank so a commit is visible one enabled cycle later.
      rd_word_d = sample_count_d;
      for (int unsigned i = 0; i < 7; i++) begin
        if (rd_addr == 3'(i)) rd_word_d = bank_d[i];
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      step_q         <= '0;
      byte_cnt_q     <= '0;
      rd_word_q      <= '0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      overrun_q      <= 1'b0;
      xfer_valid_q   <= 1'b0;
      xfer_rnw_q     <= 1'b0;
      xfer_reg_q     <= '0;
      xfer_wdata_q   <= '0;
      xfer_len_q     <= '0;
      for (int unsigned i = 0; i < 14; i++) shadow_q[i] <= '0;
      for (int unsigned i = 0; i < 7; i++) bank_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      step_q         <= step_d;
      byte_cnt_q     <= byte_cnt_d;
      rd_word_q      <= rd_word_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      overrun_q      <= overrun_d;
      xfer_valid_q   <= xfer_valid_d;
      xfer_rnw_q     <= xfer_rnw_d;
      xfer_reg_q     <= xfer_reg_d;
      xfer_wdata_q   <= xfer_wdata_d;
      xfer_len_q     <= xfer_len_d;
      for (int unsigned i = 0; i < 14; i++) shadow_q[i] <= shadow_d[i];
      for (int unsigned i = 0; i < 7; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign xfer_valid   = xfer_valid_q;
  assign xfer_rnw     = xfer_rnw_q;
  assign xfer_dev     = DEV_ADDR;
  assign xfer_reg     = xfer_reg_q;
  assign xfer_wdata   = xfer_wdata_q;
  assign xfer_len     = xfer_len_q;
  assign rd_word      = rd_word_q;
  assign sample_valid = (state_q == COMMIT);
  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mpu9250_poll_sequencer.sv
// Directed bench for mpu9250_poll_sequencer: a transaction-level model predicts
// requests, sample bank, counters and rd_word; literal checks pin key values.
module tb_mpu9250_poll_sequencer;
  localparam int unsigned PD = 64;

  logic        clk = 1'b0;
  logic        rstn, clk_en, enable, xfer_ready, rd_valid, xfer_done, xfer_nack;
  logic [7:0]  rd_data;
  logic [2:0]  rd_addr;
  logic        xfer_valid, xfer_rnw, sample_valid, overrun, busy;
  logic [6:0]  xfer_dev;
  logic [7:0]  xfer_reg, xfer_wdata, err_count;
  logic [3:0]  xfer_len;
  logic [15:0] rd_word, sample_count;

  always #5 clk = ~clk;

  mpu9250_poll_sequencer #(.DEV_ADDR(7'h68), .POLL_DIV(PD)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rstn), .clk_en(clk_en), .enable(enable),
    .xfer_valid(xfer_valid), .xfer_ready(xfer_ready), .xfer_rnw(xfer_rnw),
    .xfer_dev(xfer_dev), .xfer_reg(xfer_reg), .xfer_wdata(xfer_wdata), .xfer_len(xfer_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .xfer_done(xfer_done), .xfer_nack(xfer_nack),
    .rd_addr(rd_addr), .rd_word(rd_word), .sample_valid(sample_valid),
    .sample_count(sample_count), .err_count(err_count), .overrun(overrun), .busy(busy)
  );

  logic [7:0] tbl_reg [4] = '{8'h6B, 8'h1A, 8'h1B, 8'h1C};
  logic [7:0] tbl_dat [4] = '{8'h01, 8'h03, 8'h00, 8'h00};

  // Transaction-level model: tracks which request is due next and what the bank holds.
  logic [7:0]  m_bank [14];
  logic [7:0]  m_sh [14];
  logic [15:0] m_count, m_rdw;
  logic [7:0]  m_err;
  int          m_step, m_n;
  bit          m_rd_act, m_init_act, m_pend, m_sv;

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 14; i++) begin m_bank[i] = 8'h00; m_sh[i] = 8'h00; end
      m_count = 16'd0; m_rdw = 16'd0; m_err = 8'd0; m_step = 0; m_n = 0;
      m_rd_act = 0; m_init_act = 0; m_pend = 0; m_sv = 0;
    end else if (clk_en) begin
      m_sv = 0;
      if (m_pend) begin
        for (int i = 0; i < 14; i++) m_bank[i] = m_sh[i];
        m_count = m_count + 16'd1;
        m_pend = 0;
      end
      if (rd_addr == 3'd7) m_rdw = m_count;
      else m_rdw = {m_bank[2*rd_addr], m_bank[2*rd_addr+1]};
      if (m_rd_act) begin
        if (rd_valid && m_n < 14) begin m_sh[m_n] = rd_data; m_n++; end
        if (xfer_done) begin
          m_rd_act = 0;
          if (!xfer_nack && m_n == 14) begin m_pend = 1; m_sv = 1; end
          else if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
      end else if (m_init_act && xfer_done) begin
        m_init_act = 0;
        if (xfer_nack) begin
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end else m_step++;
      end
      if (xfer_valid && xfer_ready) begin
        if (m_step < 4) m_init_act = 1;
        else begin m_rd_act = 1; m_n = 0; end
      end
    end
  end

  int   n_checks = 0, n_errors = 0, sv_pulses = 0;
  bit   chk_on = 0, ra_force = 0;
  logic [2:0] ra_val = 3'd0, ra_auto = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 4 * PD; i++) begin
      if (xfer_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input int rdy_dly, input int nbytes, input logic [7:0] b0, input bit nack,
                     input bit coinc, input int freeze_at, input bit drop_en);
    bit ok;
    wait_valid(ok);
    if (!ok) return;
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      if (i == rdy_dly - 1) check("valid_held", xfer_valid, 1);
    end
    xfer_ready = 1'b1;
    @(negedge clk);
    xfer_ready = 1'b0;
    check("valid_dropped", xfer_valid, 0);
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      if (i == freeze_at) begin
        clk_en = 1'b0; rd_valid = 1'b1; rd_data = 8'hEE; xfer_done = 1'b1;
        repeat (50) @(negedge clk);
        check("freeze_busy", busy, 1);
        check("freeze_valid", xfer_valid, 0);
        rd_valid = 1'b0; xfer_done = 1'b0; clk_en = 1'b1;
      end
      rd_valid = 1'b1;
      rd_data  = b0 + 8'(i);
      if (coinc && i == nbytes - 1) xfer_done = 1'b1;
      @(negedge clk);
    end
    rd_valid = 1'b0;
    if (!(coinc && nbytes > 0)) begin
      xfer_done = 1'b1; xfer_nack = nack;
      @(negedge clk);
    end
    xfer_done = 1'b0; xfer_nack = 1'b0;
  endtask

  task automatic peek_word(input logic [2:0] a, input logic [15:0] exp, input string name);
    ra_force = 1; ra_val = a;
    repeat (3) @(negedge clk);
    check(name, rd_word, exp);
    ra_force = 0;
  endtask

  initial begin
    bit ok;
    int bad;
    rstn = 1'b0; clk_en = 1'b1; enable = 1'b0; xfer_ready = 1'b0; rd_valid = 1'b0;
    xfer_done = 1'b0; xfer_nack = 1'b0; rd_data = 8'h00; rd_addr = 3'd0;
    fork
      begin : compare
        forever begin
          @(negedge clk);
          rd_addr = ra_force ? ra_val : ra_auto;
          ra_auto = ra_auto + 3'd1;
          if (chk_on) begin
            check("sample_count", sample_count, m_count);
            check("err_count", err_count, m_err);
            check("sample_valid", sample_valid, m_sv);
            check("rd_word", rd_word, m_rdw);
            check("xfer_dev", xfer_dev, 7'h68);
            if (sample_valid) sv_pulses++;
            if (xfer_valid) begin
              if (m_step < 4) begin
                check("req_rnw", xfer_rnw, 0);
                check("req_reg", xfer_reg, tbl_reg[m_step]);
                check("req_wdata", xfer_wdata, tbl_dat[m_step]);
                check("req_len", xfer_len, 0);
              end else begin
                check("req_rnw", xfer_rnw, 1);
                check("req_reg", xfer_reg, 8'h3B);
                check("req_wdata", xfer_wdata, 0);
                check("req_len", xfer_len, 14);
              end
            end
          end
        end
      end
      begin : main
        repeat (3) @(negedge clk);
        check("rst_valid", xfer_valid, 0);
        check("rst_rnw", xfer_rnw, 0);
        check("rst_reg", xfer_reg, 0);
        check("rst_wdata", xfer_wdata, 0);
        check("rst_len", xfer_len, 0);
        check("rst_rd_word", rd_word, 0);
        check("rst_count", sample_count, 0);
        check("rst_err", err_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_sv", sample_valid, 0);
        rstn = 1'b1; chk_on = 1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        enable = 1'b1;
        wait_valid(ok);
        check("init0_reg", xfer_reg, 8'h6B);
        check("init0_data", xfer_wdata, 8'h01);
        check("busy_on", busy, 1);
        for (int s = 0; s < 4; s++) txn(1, 0, 8'h00, 0, 0, -1, 0);
        wait_valid(ok);
        check("read_rnw", xfer_rnw, 1);
        check("read_reg", xfer_reg, 8'h3B);
        check("read_len", xfer_len, 14);
        check("read_dev", xfer_dev, 7'h68);
        txn(1, 14, 8'h01, 0, 0, -1, 0);
        repeat (2) @(negedge clk);
        check("sv_pulses", sv_pulses, 1);
        for (int a = 0; a < 7; a++)
          peek_word(3'(a), {8'(2*a+1), 8'(2*a+2)}, "bank_word");
        peek_word(3'd7, 16'd1, "word7_count");

        txn(1, 13, 8'hA0, 0, 0, -1, 0);
        @(negedge clk);
        check("short_err", err_count, 1);
        check("short_count", sample_count, 1);
        peek_word(3'd0, 16'h0102, "short_bank_kept");

        txn(1, 14, 8'h10, 0, 1, -1, 0);
        repeat (2) @(negedge clk);
        check("coinc_count", sample_count, 2);
        peek_word(3'd6, 16'h1C1D, "coinc_gz");
        peek_word(3'd0, 16'h1011, "coinc_ax");

        txn(1, 14, 8'h40, 0, 0, 5, 0);
        repeat (2) @(negedge clk);
        check("freeze_count", sample_count, 3);
        check("freeze_no_overrun", overrun, 0);
        peek_word(3'd3, 16'h4647, "freeze_temp");

        txn(70, 14, 8'h60, 0, 0, -1, 0);
        check("overrun_set", overrun, 1);
        bad = 0;
        repeat (20) begin @(negedge clk); if (xfer_valid) bad++; end
        check("no_extra_read", bad, 0);
        check("overrun_sticky", overrun, 1);
        check("overrun_count", sample_count, 4);

        txn(1, 14, 8'h80, 0, 0, -1, 1);
        repeat (3) @(negedge clk);
        check("stop_busy", busy, 0);
        check("stop_count", sample_count, 5);
        bad = 0;
        repeat (3 * PD) begin @(negedge clk); if (xfer_valid) bad++; end
        check("stop_no_req", bad, 0);

        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1; enable = 1'b1;
        txn(1, 0, 8'h00, 0, 0, -1, 0);
        txn(1, 0, 8'h00, 0, 0, -1, 0);
        txn(1, 0, 8'h00, 1, 0, -1, 0);
        check("nack_err", err_count, 1);
        bad = 0;
        repeat (3) begin @(negedge clk); if (xfer_valid) bad++; end
        check("backoff_waits", bad, 0);
        wait_valid(ok);
        check("retry_reg", xfer_reg, 8'h1B);
        txn(1, 0, 8'h00, 0, 0, -1, 0);
        wait_valid(ok);
        check("after_retry_reg", xfer_reg, 8'h1C);
        txn(1, 0, 8'h00, 0, 0, -1, 0);
        txn(1, 14, 8'h01, 0, 0, -1, 0);
        repeat (2) @(negedge clk);
        check("nack_count", sample_count, 1);
        check("nack_overrun", overrun, 0);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
